// File: rtl/rx_frame_deframer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rx_frame_deframer_if : FIFO read port, byte stream and status bundle     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface rx_frame_deframer_if;
  logic [31:0] fifo_data;
  logic        fifo_vld;
  logic        fifo_en;
  logic [7:0]  out_data;
  logic        out_vld;
  logic        out_last;
  logic        out_rdy;
  logic        frm_err;
  logic [15:0] frm_cnt;
  logic [15:0] err_cnt;

  modport master (
    input  fifo_data, fifo_vld, out_rdy,
    output fifo_en, out_data, out_vld, out_last, frm_err, frm_cnt, err_cnt
  );

  modport slave (
    output fifo_data, fifo_vld, out_rdy,
    input  fifo_en, out_data, out_vld, out_last, frm_err, frm_cnt, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/rx_frame_deframer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rx_frame_deframer : pops header+payload words, emits a byte stream       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rx_frame_deframer #(
  parameter logic [15:0] c_MAGIC   = 16'hA55A,
  parameter int unsigned c_MAX_LEN = 1500
) (
  input  wire logic             rd_clk,
  input  wire logic             rd_rst,
  rx_frame_deframer_if.master   bus
);

  localparam logic [15:0] c_MAX_LEN_W = c_MAX_LEN[15:0];

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        frm_err_q, frm_err_d;
  logic [15:0] frm_cnt_q, frm_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        fifo_en;
  logic [15:0] hdr_len;
  logic        hdr_ok;

  assign hdr_len = bus.fifo_data[15:0];
  assign hdr_ok  = (bus.fifo_data[31:16] == c_MAGIC) && (hdr_len != 16'd0) &&
                   (hdr_len <= c_MAX_LEN_W);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    word_d    = word_q;
    frm_err_d = 1'b0;
    frm_cnt_d = frm_cnt_q;
    err_cnt_d = err_cnt_q;
    fifo_en   = 1'b0;
    case (state_q)
      HDR: begin
        fifo_en = bus.fifo_vld;
        if (bus.fifo_vld) begin
          if (hdr_ok) begin
            rem_d   = hdr_len;
            state_d = LOAD;
          end else begin
            frm_err_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          end
        end
      end
      LOAD: begin
        fifo_en = bus.fifo_vld;
        if (bus.fifo_vld) begin
          word_d  = bus.fifo_data;
          idx_d   = 2'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_rdy) begin
          rem_d = rem_q - 16'd1;
          idx_d = idx_q + 2'd1;
          // The last byte always returns to HDR so the next header is popped a cycle later.
          if (rem_q == 16'd1) begin
            state_d = HDR;
            if (frm_cnt_q != 16'hFFFF) frm_cnt_d = frm_cnt_q + 16'd1;
          end else if (idx_q == 2'd3) begin
            if (bus.fifo_vld) begin
              fifo_en = 1'b1;
              word_d  = bus.fifo_data;
              idx_d   = 2'd0;
            end else begin
              state_d = LOAD;
            end
          end
        end
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q   <= HDR;
      rem_q     <= 16'd0;
      idx_q     <= 2'd0;
      word_q    <= 32'd0;
      frm_err_q <= 1'b0;
      frm_cnt_q <= 16'd0;
      err_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      frm_err_q <= frm_err_d;
      frm_cnt_q <= frm_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.fifo_en  = fifo_en;
  assign bus.out_vld  = (state_q == EMIT);
  assign bus.out_last = (state_q == EMIT) && (rem_q == 16'd1);
  assign bus.out_data = word_q[{idx_q, 3'b000} +: 8];
  assign bus.frm_err  = frm_err_q;
  assign bus.frm_cnt  = frm_cnt_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule
`default_nettype wire
